// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - floor codes, state encoding and floor-command table for the elevator scheduler
package elevator_pkg;

    localparam logic [1:0] FLOOR0    = 2'b00;
    localparam logic [1:0] FLOOR1    = 2'b01;
    localparam logic [1:0] FLOOR2    = 2'b10;
    localparam logic [1:0] FLOOR_INV = 2'b11;

    // Command held on {B0,B1} when the car is parked at a floor
    localparam logic [1:0] HOLD_F0 = 2'b00;
    localparam logic [1:0] HOLD_F1 = 2'b01;
    localparam logic [1:0] HOLD_F2 = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_OPEN  = 3'd1,
        ST_CLOSE = 3'd2,
        ST_MOVE  = 3'd3,
        ST_FAULT = 3'd4
    } state_e;

    // One-hot mask of a floor code; the invalid code maps to no floor
    function automatic logic [2:0] floor_onehot(input logic [1:0] floor);
        case (floor)
            FLOOR0:  floor_onehot = 3'b001;
            FLOOR1:  floor_onehot = 3'b010;
            FLOOR2:  floor_onehot = 3'b100;
            default: floor_onehot = 3'b000;
        endcase
    endfunction

    // {B0,B1} for the floor FSM: travel codes only while moving toward another floor
    function automatic logic [1:0] cmd_code(input logic [1:0] ea, input logic [1:0] target,
                                            input logic moving);
        if (ea == FLOOR_INV) begin
            cmd_code = 2'b00;
        end else if (moving && (ea != target)) begin
            case ({ea, target})
                {FLOOR0, FLOOR1}: cmd_code = 2'b01;
                {FLOOR0, FLOOR2}: cmd_code = 2'b10;
                {FLOOR1, FLOOR0}: cmd_code = 2'b00;
                {FLOOR1, FLOOR2}: cmd_code = 2'b11;
                {FLOOR2, FLOOR0}: cmd_code = 2'b00;
                {FLOOR2, FLOOR1}: cmd_code = 2'b01;
                default:          cmd_code = 2'b00;
            endcase
        end else begin
            case (ea)
                FLOOR0:  cmd_code = HOLD_F0;
                FLOOR1:  cmd_code = HOLD_F1;
                default: cmd_code = HOLD_F2;
            endcase
        end
    endfunction

endpackage

// File: rtl/elevator_scheduler_scan_select.sv
// rtl/elevator_scheduler_scan_select.sv - SCAN next-floor selector (combinational)
module scan_select
    import elevator_pkg::*;
(
    input  logic [2:0] pending_i,
    input  logic [1:0] ea_i,
    input  logic       dir_up_i,
    output logic [1:0] target_o,
    output logic       new_dir_o,
    output logic       none_ahead_o,
    output logic       here_only_o
);

    logic       has_up;
    logic       has_dn;
    logic [1:0] up_t;
    logic [1:0] dn_t;
    logic       ahead;
    logic       behind;

    // Nearest pending floor above and below the current floor (current floor itself excluded)
    always_comb begin
        has_up = 1'b0;
        up_t   = ea_i;
        for (int i = 2; i >= 0; i--) begin
            if ((i > int'(ea_i)) && pending_i[i]) begin
                has_up = 1'b1;
                up_t   = 2'(i);
            end
        end
        has_dn = 1'b0;
        dn_t   = ea_i;
        for (int i = 0; i < 3; i++) begin
            if ((i < int'(ea_i)) && pending_i[i]) begin
                has_dn = 1'b1;
                dn_t   = 2'(i);
            end
        end
    end

    // Keep direction while anything lies ahead; otherwise reverse toward what lies behind
    always_comb begin
        ahead        = dir_up_i ? has_up : has_dn;
        behind       = dir_up_i ? has_dn : has_up;
        none_ahead_o = ~ahead;
        new_dir_o    = (~ahead && behind) ? ~dir_up_i : dir_up_i;
        if (ahead) begin
            target_o = dir_up_i ? up_t : dn_t;
        end else if (behind) begin
            target_o = dir_up_i ? dn_t : up_t;
        end else begin
            target_o = ea_i;
        end
        here_only_o = (ea_i != FLOOR_INV) && (pending_i == floor_onehot(ea_i));
    end

endmodule

// File: rtl/elevator_scheduler.sv
// rtl/elevator_scheduler.sv - call latch, SCAN scheduling and door sequencing for a three-floor car
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int OPEN_CYCLES  = 8,
    parameter int DOOR_CYCLES  = 4,
    parameter int MOVE_TIMEOUT = 8,
    parameter int TW           = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] call_req,
    input  logic       obstruct,
    input  logic [1:0] EA,
    output logic       P,
    output logic       B0,
    output logic       B1,
    output logic [2:0] pending,
    output logic       door_open,
    output logic       dir_up,
    output logic       fault
);

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    target_q, target_d;
    logic          dir_up_q, dir_up_d;
    logic          p_q, p_d;
    logic          fault_q, fault_d;
    logic [2:0]    pending_q, pending_d;

    logic          ea_valid;
    logic [2:0]    ea_mask;
    logic          call_here;
    logic          enter_open;
    logic [2:0]    set_mask;

    logic [1:0]    sel_target;
    logic          sel_new_dir;
    logic          sel_none_ahead;
    logic          sel_here_only;

    scan_select u_scan_select (
        .pending_i    (pending_q),
        .ea_i         (EA),
        .dir_up_i     (dir_up_q),
        .target_o     (sel_target),
        .new_dir_o    (sel_new_dir),
        .none_ahead_o (sel_none_ahead),
        .here_only_o  (sel_here_only)
    );

    assign ea_valid  = (EA != FLOOR_INV);
    assign ea_mask   = floor_onehot(EA);
    assign call_here = ea_valid && (|(call_req & ea_mask));

    // Next state, door/move timer, target and direction
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        target_d = target_q;
        dir_up_d = dir_up_q;
        if ((state_q != ST_FAULT) && !ea_valid) begin
            state_d = ST_FAULT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (call_here) begin
                        state_d = ST_OPEN;
                        timer_d = '0;
                    end else if (|pending_q) begin
                        state_d = ST_CLOSE;
                        timer_d = '0;
                    end
                end
                ST_OPEN: begin
                    if (call_here) begin
                        timer_d = '0;
                    end else if (timer_q == TW'(OPEN_CYCLES - 1)) begin
                        state_d = (|pending_q) ? ST_CLOSE : ST_IDLE;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                ST_CLOSE: begin
                    if (obstruct || call_here) begin
                        state_d = ST_OPEN;
                        timer_d = '0;
                    end else if (timer_q == TW'(DOOR_CYCLES - 1)) begin
                        timer_d = '0;
                        if (pending_q == 3'b000) begin
                            state_d = ST_IDLE;
                        end else if (sel_here_only) begin
                            state_d = ST_OPEN;
                        end else begin
                            state_d  = ST_MOVE;
                            target_d = sel_target;
                            dir_up_d = sel_none_ahead ? sel_new_dir : dir_up_q;
                        end
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                ST_MOVE: begin
                    if (EA == target_q) begin
                        state_d = ST_OPEN;
                        timer_d = '0;
                    end else if (timer_q == TW'(MOVE_TIMEOUT - 1)) begin
                        state_d = ST_FAULT;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_FAULT;
                end
            endcase
        end
    end

    // Call latch: calls at the open floor are absorbed, arrival clears (clear beats set), frozen in FAULT
    always_comb begin
        p_d        = (state_d == ST_MOVE);
        fault_d    = fault_q | (state_d == ST_FAULT);
        enter_open = (state_d == ST_OPEN) && (state_q != ST_OPEN);
        set_mask   = call_req;
        if ((state_q == ST_IDLE) || (state_q == ST_OPEN)) begin
            set_mask = call_req & ~ea_mask;
        end
        if ((state_q == ST_FAULT) || (state_d == ST_FAULT)) begin
            pending_d = pending_q;
        end else begin
            pending_d = (pending_q | set_mask) & ~(enter_open ? ea_mask : 3'b000);
        end
    end

    // Scheduler FSM state and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            target_q  <= FLOOR0;
            dir_up_q  <= 1'b1;
            p_q       <= 1'b0;
            fault_q   <= 1'b0;
            pending_q <= 3'b000;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            target_q  <= target_d;
            dir_up_q  <= dir_up_d;
            p_q       <= p_d;
            fault_q   <= fault_d;
            pending_q <= pending_d;
        end
    end

    assign {B0, B1}  = cmd_code(EA, target_q, state_q == ST_MOVE);
    assign P         = p_q;
    assign pending   = pending_q;
    assign door_open = (state_q == ST_IDLE) || (state_q == ST_OPEN);
    assign dir_up    = dir_up_q;
    assign fault     = fault_q;

endmodule
